// File: rtl/core_mem_arbiter_pkg.sv
// core_mem_arbiter_pkg
// Shared declarations for the TOY core main-memory arbiter: the arbiter FSM
// state type and the default address that maps onto stdin/stdout.
package core_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IFU_WAIT,
    LSU_WAIT,
    IO_IN,
    IO_OUT
  } mem_arb_state_e;

  localparam logic [7:0] IO_ADDR_DEF = 8'hFF;

endpackage

// File: rtl/core_mem_stdio.sv
// core_mem_stdio
// stdin/stdout handshake helper for core_mem_arbiter. The arbiter tells it
// which I/O wait state is active; it drives the handshake outputs, keeps the
// stdout data register and reports the completing handshake cycle.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_in_act            arbiter is in IO_IN
//   i_out_act           arbiter is in IO_OUT
//   i_out_load          capture i_wdata into the stdout register
//   i_wdata             store data from the LSU
//   i_stdin_valid, o_stdin_ready, i_stdin_data     stdin handshake
//   o_stdout_valid, i_stdout_ready, o_stdout_data  stdout handshake
//   o_done, o_rdata     handshake completed this cycle / stdin word
module core_mem_stdio #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_act,
  input  logic              i_out_act,
  input  logic              i_out_load,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_stdin_valid,
  output logic              o_stdin_ready,
  input  logic [DATA_W-1:0] i_stdin_data,
  output logic              o_stdout_valid,
  input  logic              i_stdout_ready,
  output logic [DATA_W-1:0] o_stdout_data,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_out_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_data <= '0;
    end else if (i_out_load) begin
      r_out_data <= i_wdata;
    end
  end

  always_comb begin
    o_stdin_ready  = i_in_act;
    o_stdout_valid = i_out_act;
    o_stdout_data  = i_out_act ? r_out_data : '0;
    o_done         = 1'b0;
    o_rdata        = '0;
    if (i_in_act && i_stdin_valid) begin
      o_done  = 1'b1;
      o_rdata = i_stdin_data;
    end
    if (i_out_act && i_stdout_ready) begin
      o_done = 1'b1;
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
// Single-port main-memory controller for the TOY core. Shares the memory port
// between instruction fetch (ifu_*) and decode's load/store preempt path
// (lsu_*). With CORE_MEM_STDIO_EN defined, accesses to IO_ADDR become
// stdin (load) / stdout (store) handshakes via core_mem_stdio; otherwise
// IO_ADDR is ordinary memory and the stdio outputs are tied low.
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   ifu_req_i/addr_i/gnt_o/rvalid_o/rdata_o   fetch request and response
//   lsu_req_i/wen_i/addr_i/wdata_i/done_o/rdata_o  load/store request
//   mem_en_o/wen_o/addr_o/wdata_o, mem_rdata_i     memory macro port
//   stdin_*, stdout_*                  console handshakes
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int unsigned           ADDR_W  = 8,
  parameter int unsigned           DATA_W  = 16,
  parameter logic [ADDR_W-1:0]     IO_ADDR = ADDR_W'(IO_ADDR_DEF)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ifu_req_i,
  input  logic [ADDR_W-1:0] ifu_addr_i,
  output logic              ifu_gnt_o,
  output logic              ifu_rvalid_o,
  output logic [DATA_W-1:0] ifu_rdata_o,
  input  logic              lsu_req_i,
  input  logic              lsu_wen_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic              lsu_done_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              mem_en_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              stdin_valid_i,
  output logic              stdin_ready_o,
  input  logic [DATA_W-1:0] stdin_data_i,
  output logic              stdout_valid_o,
  input  logic              stdout_ready_i,
  output logic [DATA_W-1:0] stdout_data_o
);

  mem_arb_state_e    r_state;
  mem_arb_state_e    w_next;
  logic              r_fetch_pri;
  logic              r_lsu_block;
  logic              w_lsu_req;
  logic              w_gnt_lsu;
  logic              w_gnt_ifu;
  logic              w_lsu_io;
  logic              w_io_done;
  logic [DATA_W-1:0] w_io_rdata;
  logic              w_done;

  // r_lsu_block masks the still-high request seen in the completion cycle;
  // it clears once the LSU has dropped req for a cycle. Grants are gated by
  // rst_i so every output reads 0 while reset is held.
  assign w_lsu_req = lsu_req_i & ~r_lsu_block & ~rst_i;
  assign w_gnt_lsu = (r_state == IDLE) & w_lsu_req & ~(r_fetch_pri & ifu_req_i);
  assign w_gnt_ifu = (r_state == IDLE) & ~rst_i & ifu_req_i & ~w_gnt_lsu;
  assign w_done    = (r_state == LSU_WAIT) | w_io_done;

`ifdef CORE_MEM_STDIO_EN
  assign w_lsu_io = (lsu_addr_i == IO_ADDR);

  core_mem_stdio #(
    .DATA_W(DATA_W)
  ) u_stdio (
    .i_clk          (clk_i),
    .i_rst          (rst_i),
    .i_in_act       (r_state == IO_IN),
    .i_out_act      (r_state == IO_OUT),
    .i_out_load     (w_gnt_lsu & w_lsu_io & lsu_wen_i),
    .i_wdata        (lsu_wdata_i),
    .i_stdin_valid  (stdin_valid_i),
    .o_stdin_ready  (stdin_ready_o),
    .i_stdin_data   (stdin_data_i),
    .o_stdout_valid (stdout_valid_o),
    .i_stdout_ready (stdout_ready_i),
    .o_stdout_data  (stdout_data_o),
    .o_done         (w_io_done),
    .o_rdata        (w_io_rdata)
  );
`else
  logic w_unused_io;

  assign w_lsu_io       = 1'b0;
  assign w_io_done      = 1'b0;
  assign w_io_rdata     = '0;
  assign stdin_ready_o  = 1'b0;
  assign stdout_valid_o = 1'b0;
  assign stdout_data_o  = '0;
  assign w_unused_io    = ^{stdin_valid_i, stdin_data_i, stdout_ready_i, IO_ADDR};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_fetch_pri <= 1'b0;
      r_lsu_block <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_done) begin
        r_fetch_pri <= 1'b1;
      end else if (w_gnt_ifu) begin
        r_fetch_pri <= 1'b0;
      end
      if (w_done) begin
        r_lsu_block <= 1'b1;
      end else if (!lsu_req_i) begin
        r_lsu_block <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt_lsu) begin
          if (w_lsu_io) begin
            w_next = lsu_wen_i ? IO_OUT : IO_IN;
          end else begin
            w_next = LSU_WAIT;
          end
        end else if (w_gnt_ifu) begin
          w_next = IFU_WAIT;
        end
      end
      IFU_WAIT: w_next = IDLE;
      LSU_WAIT: w_next = IDLE;
`ifdef CORE_MEM_STDIO_EN
      IO_IN:    w_next = w_io_done ? IDLE : IO_IN;
      IO_OUT:   w_next = w_io_done ? IDLE : IO_OUT;
`endif
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    ifu_gnt_o    = 1'b0;
    ifu_rvalid_o = 1'b0;
    ifu_rdata_o  = '0;
    lsu_done_o   = 1'b0;
    lsu_rdata_o  = '0;
    mem_en_o     = 1'b0;
    mem_wen_o    = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    case (r_state)
      IDLE: begin
        if (w_gnt_lsu && !w_lsu_io) begin
          mem_en_o    = 1'b1;
          mem_wen_o   = lsu_wen_i;
          mem_addr_o  = lsu_addr_i;
          mem_wdata_o = lsu_wdata_i;
        end else if (w_gnt_ifu) begin
          mem_en_o   = 1'b1;
          mem_addr_o = ifu_addr_i;
          ifu_gnt_o  = 1'b1;
        end
      end
      IFU_WAIT: begin
        ifu_rvalid_o = 1'b1;
        ifu_rdata_o  = mem_rdata_i;
      end
      LSU_WAIT: begin
        lsu_done_o  = 1'b1;
        lsu_rdata_o = lsu_wen_i ? '0 : mem_rdata_i;
      end
      default: ;
    endcase
    if (w_io_done) begin
      lsu_done_o  = 1'b1;
      lsu_rdata_o = w_io_rdata;
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
`timescale 1ns/1ps
module tb_core_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          ifu_req_i = 1'b0;
  logic [AW-1:0] ifu_addr_i = '0;
  logic          ifu_gnt_o, ifu_rvalid_o;
  logic [DW-1:0] ifu_rdata_o;
  logic          lsu_req_i = 1'b0, lsu_wen_i = 1'b0;
  logic [AW-1:0] lsu_addr_i = '0;
  logic [DW-1:0] lsu_wdata_i = '0;
  logic          lsu_done_o;
  logic [DW-1:0] lsu_rdata_o;
  logic          mem_en_o, mem_wen_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          stdin_valid_i = 1'b0, stdin_ready_o;
  logic [DW-1:0] stdin_data_i = '0;
  logic          stdout_valid_o, stdout_ready_i = 1'b0;
  logic [DW-1:0] stdout_data_o;

  always #5 clk_i = ~clk_i;

  core_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .IO_ADDR(8'hFF)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(ifu_gnt_o),
    .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_wen_i(lsu_wen_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_done_o(lsu_done_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_en_o(mem_en_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .stdin_valid_i(stdin_valid_i), .stdin_ready_o(stdin_ready_o), .stdin_data_i(stdin_data_i),
    .stdout_valid_o(stdout_valid_o), .stdout_ready_i(stdout_ready_i), .stdout_data_o(stdout_data_o)
  );

  function automatic logic [DW-1:0] init_val(input int unsigned a);
    if (a == 32'h10) return 16'h7A05;
    if (a == 32'h20) return 16'h1234;
    return 16'((a * 32'h9E37) ^ 32'h5A5A);
  endfunction

  // Memory macro: one-cycle read latency.
  logic          mem_clr = 1'b1;
  logic [DW-1:0] mem [256];
  always @(posedge clk_i) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (mem_en_o) begin
      if (mem_wen_o) mem[mem_addr_o] <= mem_wdata_o;
      mem_rdata_i <= mem[mem_addr_o];
    end
  end

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: per-transaction expectations from the access rules.
  logic [DW-1:0] ref_mem [256];
  bit            m_pend_f, m_pend_l, m_lwen, m_pri, m_armed;
  logic [AW-1:0] m_faddr, m_laddr;
  logic [DW-1:0] m_lwdata;
  logic          s_gnt, s_en, s_wen, s_done, s_rv;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_lrdata, s_frdata;

  task automatic model_reset();
    m_pend_f = 0; m_pend_l = 0; m_pri = 0; m_armed = 1;
    s_gnt = 0; s_done = 0;
  endtask

  // Called at a falling edge with this cycle's inputs already applied.
  task automatic tick();
    logic e_gnt, e_en, e_wen, e_rv, e_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_frd, e_lrd;
    #1;
    e_gnt = 0; e_en = 0; e_wen = 0; e_rv = 0; e_done = 0;
    e_addr = '0; e_frd = '0; e_lrd = '0;
    if (m_pend_f) begin
      e_rv = 1; e_frd = ref_mem[m_faddr]; m_pend_f = 0;
    end else if (m_pend_l) begin
      e_done = 1;
      if (m_lwen) ref_mem[m_laddr] = m_lwdata;
      else e_lrd = ref_mem[m_laddr];
      m_pend_l = 0; m_pri = 1;
    end else if (lsu_req_i && m_armed && !(m_pri && ifu_req_i)) begin
      e_en = 1; e_wen = lsu_wen_i; e_addr = lsu_addr_i;
      m_pend_l = 1; m_laddr = lsu_addr_i; m_lwen = lsu_wen_i; m_lwdata = lsu_wdata_i;
      chk("mem_wdata", mem_wdata_o, lsu_wdata_i);
    end else if (ifu_req_i) begin
      e_en = 1; e_gnt = 1; e_addr = ifu_addr_i;
      m_pend_f = 1; m_faddr = ifu_addr_i; m_pri = 0;
    end
    if (e_done) m_armed = 0;
    else if (!lsu_req_i) m_armed = 1;
    chk("mem_en", mem_en_o, e_en);
    chk("mem_wen", mem_wen_o, e_wen);
    chk("mem_addr", mem_addr_o, e_addr);
    chk("ifu_gnt", ifu_gnt_o, e_gnt);
    chk("ifu_rvalid", ifu_rvalid_o, e_rv);
    chk("ifu_rdata", ifu_rdata_o, e_frd);
    chk("lsu_done", lsu_done_o, e_done);
    chk("lsu_rdata", lsu_rdata_o, e_lrd);
    chk("stdin_ready_idle", stdin_ready_o, 0);
    chk("stdout_valid_idle", stdout_valid_o, 0);
    s_gnt = ifu_gnt_o; s_en = mem_en_o; s_wen = mem_wen_o; s_addr = mem_addr_o;
    s_done = lsu_done_o; s_rv = ifu_rvalid_o; s_lrdata = lsu_rdata_o; s_frdata = ifu_rdata_o;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1; ifu_req_i = 1; ifu_addr_i = 8'h10;
    lsu_req_i = 1; lsu_wen_i = 0; lsu_addr_i = 8'h20;
    #1;
    chk("rst_mem_en", mem_en_o, 0);
    chk("rst_ifu_gnt", ifu_gnt_o, 0);
    chk("rst_rvalid", ifu_rvalid_o, 0);
    chk("rst_lsu_done", lsu_done_o, 0);
    chk("rst_stdin_ready", stdin_ready_o, 0);
    chk("rst_stdout_valid", stdout_valid_o, 0);
    chk("rst_stdout_data", stdout_data_o, 0);
    @(negedge clk_i);
    ifu_req_i = 0; lsu_req_i = 0; stdin_valid_i = 0; stdout_ready_i = 0;
    rst_i = 0;
    model_reset();
  endtask

  task automatic lsu_set(input logic req, input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
    lsu_req_i = req; lsu_wen_i = wen; lsu_addr_i = a; lsu_wdata_i = d;
  endtask

  bit stale;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    @(negedge clk_i);
    mem_clr = 0;
    do_reset();

    // Single fetch.
    ifu_req_i = 1; ifu_addr_i = 8'h10;
    tick(); chk("t1_gnt", s_gnt, 1);
    ifu_req_i = 0;
    tick(); chk("t1_rdata", s_frdata, 16'h7A05);

    // Simultaneous fetch and load: LSU first, then fetch.
    ifu_req_i = 1; ifu_addr_i = 8'h40; lsu_set(1, 0, 8'h20, '0);
    tick(); chk("t2_lsu_first", s_gnt, 0);
    tick(); chk("t2_ld_data", s_lrdata, 16'h1234);
    lsu_req_i = 0;
    tick(); chk("t2_fetch_next", s_gnt, 1);
    ifu_req_i = 0; lsu_set(1, 0, 8'h20, '0);
    tick(); tick(); tick(); chk("t2_ld2_done", s_done, 1);
    lsu_req_i = 0;
    tick();
    // Both raised again with fetch priority pending.
    ifu_req_i = 1; ifu_addr_i = 8'h10; lsu_req_i = 1;
    tick(); chk("t2_pri_fetch", s_gnt, 1);
    ifu_req_i = 0;
    tick(); tick(); tick();
    lsu_req_i = 0;
    tick();

    // Store then load back.
    lsu_set(1, 1, 8'h30, 16'hBEEF);
    tick(); chk("t3_st_wen", s_wen, 1); chk("t3_st_addr", s_addr, 8'h30);
    tick(); chk("t3_st_done", s_done, 1);
    lsu_req_i = 0;
    tick();
    lsu_set(1, 0, 8'h30, '0);
    tick(); tick(); chk("t3_ld_data", s_lrdata, 16'hBEEF);
    lsu_req_i = 0;
    tick();

`ifdef CORE_MEM_STDIO_EN
    // stdin load with a delayed producer.
    lsu_set(1, 0, 8'hFF, '0); stdin_valid_i = 0;
    #1; chk("io_in_grant_noen", mem_en_o, 0); chk("io_in_grant_done", lsu_done_o, 0);
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("io_in_ready", stdin_ready_o, 1);
      chk("io_in_noen", mem_en_o, 0);
      chk("io_in_wait_done", lsu_done_o, 0);
      @(negedge clk_i);
    end
    stdin_valid_i = 1; stdin_data_i = 16'h0042;
    #1;
    chk("io_in_ready_hs", stdin_ready_o, 1);
    chk("io_in_done", lsu_done_o, 1);
    chk("io_in_rdata", lsu_rdata_o, 16'h0042);
    chk("io_in_hs_noen", mem_en_o, 0);
    @(negedge clk_i);
    lsu_req_i = 0; stdin_valid_i = 0;
    #1; chk("io_in_ready_off", stdin_ready_o, 0);
    @(negedge clk_i);

    // stdout store, aborted by reset while waiting.
    lsu_set(1, 1, 8'hFF, 16'h0007); stdout_ready_i = 0;
    #1; chk("io_out_grant_noen", mem_en_o, 0);
    @(negedge clk_i);
    lsu_wdata_i = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("io_out_valid", stdout_valid_o, 1);
      chk("io_out_data", stdout_data_o, 16'h0007);
      chk("io_out_wait_done", lsu_done_o, 0);
      chk("io_out_noen", mem_en_o, 0);
      @(negedge clk_i);
    end
    do_reset();
`else
    // IO_ADDR behaves as plain memory.
    lsu_set(1, 0, 8'hFF, '0);
    tick(); chk("t4_mem_en", s_en, 1); chk("t4_addr", s_addr, 8'hFF);
    tick(); chk("t4_rdata", s_lrdata, init_val(8'hFF));
    lsu_req_i = 0;
    tick();
`endif

    // Randomized traffic.
    do_reset();
    stale = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (ifu_req_i) begin
        if (s_gnt || $urandom_range(0, 19) == 0) ifu_req_i = 0;
      end else if ($urandom_range(0, 1) == 1) begin
        ifu_req_i = 1; ifu_addr_i = 8'($urandom_range(0, 31));
      end
      if (lsu_req_i) begin
        if (s_done) begin
          if ($urandom_range(0, 3) == 0) stale = 1;
          else lsu_req_i = 0;
        end else if (stale && $urandom_range(0, 1) == 1) begin
          lsu_req_i = 0; stale = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        lsu_set(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 16'($urandom));
`ifndef CORE_MEM_STDIO_EN
        if ($urandom_range(0, 15) == 0) lsu_addr_i = 8'hFF;
`endif
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Single-port main-memory controller for the TOY core. It shares the one memory port between instruction fetch (IFU) and the load/store requests that decode raises on its preempt interface (LSU). It also maps TOY address 0xFF onto stdin/stdout handshakes. It sits between the fetch stage, the decoder's preempt path and the memory macro, and sequences every memory and I/O access.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 16, word width
- IO_ADDR, 8'hFF, address mapped to stdin/stdout (only with the I/O macro)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- ifu_req_i  in  1  fetch request; held with ifu_addr_i until granted
- ifu_addr_i  in  ADDR_W  fetch address (pc)
- ifu_gnt_o  out  1  fetch accepted this cycle
- ifu_rvalid_o  out  1  fetch data valid (one-cycle pulse)
- ifu_rdata_o  out  DATA_W  fetched instruction
- lsu_req_i  in  1  load/store request; held with its addr/wen/wdata until lsu_done_o
- lsu_wen_i  in  1  1 = store, 0 = load
- lsu_addr_i  in  ADDR_W  data address
- lsu_wdata_i  in  DATA_W  store data
- lsu_done_o  out  1  access complete (one-cycle pulse)
- lsu_rdata_o  out  DATA_W  load data, valid with lsu_done_o
- mem_en_o, mem_wen_o  out  1  memory strobe / write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  read data, valid the cycle after mem_en_o
- stdin_valid_i / stdin_ready_o  in/out  1  stdin handshake
- stdin_data_i  in  DATA_W  stdin word
- stdout_valid_o / stdout_ready_i  out/in  1  stdout handshake
- stdout_data_o  out  DATA_W  stdout word

## Operation
- FSM states: IDLE, IFU_WAIT, LSU_WAIT, IO_IN, IO_OUT.
- **IDLE arbitration**
  - LSU wins unless the `fetch_pri` flag is set and ifu_req_i is high.
  - `fetch_pri` sets when an LSU access completes and clears on the next fetch grant. This guarantees one fetch between back-to-back LSU accesses.
- **Fetch grant (IDLE)**
  - Drive mem_en_o=1, mem_wen_o=0, mem_addr_o=ifu_addr_i, ifu_gnt_o=1, then go to IFU_WAIT.
  - IFU_WAIT: ifu_rvalid_o=1 and ifu_rdata_o=mem_rdata_i, then go to IDLE.
- **LSU grant (IDLE), address not IO_ADDR**
  - Drive mem_en_o=1, mem_wen_o=lsu_wen_i, mem_addr_o=lsu_addr_i, mem_wdata_o=lsu_wdata_i, then go to LSU_WAIT.
  - LSU_WAIT: lsu_done_o=1; for loads lsu_rdata_o=mem_rdata_i. Then go to IDLE.
- **LSU grant, address IO_ADDR, load** → IO_IN.
  - Hold stdin_ready_o=1 until stdin_valid_i.
  - In the handshake cycle: lsu_done_o=1, lsu_rdata_o=stdin_data_i, then go to IDLE.
- **LSU grant, address IO_ADDR, store** → IO_OUT.
  - Latch lsu_wdata_i into stdout_data_o and hold stdout_valid_o=1 until stdout_ready_i.
  - In the handshake cycle: lsu_done_o=1, then go to IDLE.
- I/O accesses never strobe memory.
- While IO_IN or IO_OUT waits, ifu_gnt_o stays 0; the core is already stalled by decode.
- Outputs not named in a state are 0. Data outputs are 0 outside their valid cycle.

## Timing
- Reset: state=IDLE, fetch_pri=0, and every output is 0, including stdout_valid_o and stdin_ready_o.
- Fetch: request granted in cycle N, data in N+1. Next grant no earlier than N+2. Peak throughput is 1 access per 2 cycles.
- LSU memory access: grant in N, lsu_done_o in N+1.
- I/O access: lsu_done_o in the handshake cycle, which is at least N+1.
- Simultaneous ifu_req_i and lsu_req_i with fetch_pri=0: LSU granted, fetch waits. After the LSU completes, the fetch is granted first.
- A requester dropping its req before grant is legal; nothing is issued.
- lsu_req_i still high in the cycle of lsu_done_o is not a new request. A new LSU request is recognised only after req has been low for at least one cycle.
- Reset mid-operation aborts immediately, with no completion pulse.
  - A partially waited stdin word is not consumed.
  - stdout_valid_o drops with no transfer.
  - A memory write issued in cycle N is not undone.

## Configuration
- `CORE_MEM_STDIO_EN` defined: IO_ADDR decoding, IO_IN/IO_OUT states and the stdin/stdout ports are active.
- Not defined: IO_ADDR is ordinary memory, both I/O states are removed, stdin_ready_o and stdout_valid_o are tied 0, and stdout_data_o is tied 0.

## Structure
- In the shared core package: the `mem_arb_state_e` enum and the `IO_ADDR` default constant.
- One sub-module, `core_mem_stdio`, holds the IO_IN/IO_OUT handshake and the stdout data register. It is instantiated only under the macro.

## Test plan
- Reset, then ifu_req_i=1, ifu_addr_i=0x10, mem[0x10]=0x7A05 → ifu_gnt_o in N, ifu_rvalid_o with rdata 0x7A05 in N+1.
- ifu_req_i and lsu_req_i (load 0x20, mem=0x1234) raised together → LSU served first (lsu_done_o, rdata 0x1234), then the fetch is granted before a second back-to-back LSU request.
- LSU store 0xBEEF to 0x30 → mem_wen_o=1 and mem_addr_o=0x30 in N, lsu_done_o in N+1; a later load of 0x30 returns 0xBEEF.
- With the macro: load 0xFF, stdin_valid_i held low for 5 cycles then 0x0042 → stdin_ready_o high throughout, lsu_done_o with 0x0042 on the handshake cycle, no mem_en_o.
- With the macro: store 0xFF of 0x0007, stdout_ready_i low 3 cycles → stdout_valid_o with 0x0007 held; rst_i asserted mid-wait → all outputs 0 immediately, no lsu_done_o.
- Without the macro: load 0xFF → ordinary memory read of mem[0xFF] in N+1.
